mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the datapath's instruction-fetch and data load/store requests onto one shared single-port memory port.
- Drives the memory side of the datapath memory interface:
  - consumes imem_ren/imem_addr and dmem_ren/dmem_wen/dmem_addr/dmem_store/dmem_width;
  - returns imem_load/ihit and dmem_load/dhit.
- Sequences each access with a request/ready handshake to RAM.
- Generates byte strobes and aligns sub-word loads.
- Gives data priority, with an anti-starvation limit for fetches.

Parameters:
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- LDST_WIDTH_W, 2, width of dmem_width; encoding 0=byte, 1=half, 2=word, 3=word.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before a fetch is forced (1..15).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- imem_ren  in  1  fetch request (level; held until ihit).
- imem_addr  in  ADDR_W  fetch byte address.
- dmem_ren  in  1  load request (level; held until dhit).
- dmem_wen  in  1  store request (level; held until dhit); wins over dmem_ren if both are set.
- dmem_addr  in  ADDR_W  load/store byte address.
- dmem_store  in  DATA_W  store data, right-justified.
- dmem_width  in  LDST_WIDTH_W  access width.
- imem_load  out  DATA_W  fetched word, valid while ihit=1.
- ihit  out  1  one-cycle fetch-complete pulse.
- dmem_load  out  DATA_W  load data, right-justified and zero-extended, valid while dhit=1.
- dhit  out  1  one-cycle data-complete pulse.
- dmem_misaligned  out  1  one-cycle pulse together with dhit when the data access was misaligned.
- ram_req  out  1  RAM access request; held until ram_ready.
- ram_wen  out  1  1 = write, 0 = read; stable while ram_req=1.
- ram_addr  out  ADDR_W  word address: byte address with bits [1:0] forced to 0.
- ram_wstrb  out  4  write byte enables; 4'b0000 on reads.
- ram_wdata  out  DATA_W  store data replicated to the target lanes.
- ram_rdata  in  DATA_W  read data, valid in the ram_ready cycle.
- ram_ready  in  1  one-cycle pulse: access complete; may arrive as early as the first ram_req cycle.

Behaviour:
- Reset (nRST=0, asynchronous):
  - state=IDLE, starve counter=0;
  - ram_req, ram_wen, ram_wstrb, ram_wdata, ram_addr, ihit, dhit, imem_load, dmem_load and dmem_misaligned all go to 0 immediately.
  - Any in-flight RAM access is abandoned; a ram_ready arriving later is ignored while in IDLE.
- FSM states: IDLE, DACC, IACC, RESP.
- IDLE: grant decision each cycle.
  - Data request pending (dmem_ren|dmem_wen) and imem not starved -> DACC.
  - Otherwise imem_ren -> IACC.
  - Otherwise stay in IDLE.
  - Starved means imem_ren=1 and starve counter == STARVE_MAX; a starved fetch goes to IACC even with a data request pending.
- On entry to DACC/IACC: ram_req, ram_wen, ram_addr, ram_wstrb and ram_wdata are registered from the request and held constant until ram_ready.
- DACC/IACC: wait for ram_ready. When it arrives:
  - register the aligned load data;
  - drop ram_req on the next edge;
  - go to RESP.
- RESP (exactly 1 cycle):
  - ihit or dhit = 1 for the serviced requester;
  - imem_load/dmem_load is valid; dmem_misaligned is valid;
  - next state is IDLE; requests are not sampled in RESP.
- Latency: minimum 3 cycles from request sampled in IDLE to the hit pulse (IDLE edge, ram_ready in the first ACC cycle, RESP); back-to-back throughput is one access per 3 cycles.
- Starve counter:
  - +1 (saturating at STARVE_MAX) on each DACC grant while imem_ren=1;
  - reset to 0 on any IACC grant, or when imem_ren=0 in IDLE.
- Width and strobes (offset = addr[1:0]):
  - byte: wstrb = 1 << offset; wdata = store[7:0] in all lanes; load = rdata byte[offset], zero-extended.
  - half: wstrb = 4'b0011 << (offset[1]*2); wdata = store[15:0] in both halves; load = rdata half[offset[1]], zero-extended.
  - word: wstrb = 4'b1111; load = rdata.
- Misalignment:
  - half with offset[0]=1, or word with offset != 0;
  - the access is still performed with the offset bits of that width masked (half uses offset[1], word uses offset 0);
  - dmem_misaligned pulses with dhit.
- Fetches are always full-word reads; imem_addr[1:0] is ignored.
- Simultaneous dmem_ren and dmem_wen: treated as a write.
- A request deasserted while its access is in flight: the access still completes and the hit still pulses.

Test Plan:
- Reset, then imem_ren=1, imem_addr=0x100, ram_ready on the first ACC cycle, ram_rdata=0x00A00093 -> ram_req high 1 cycle with ram_addr=0x100; ihit pulses exactly 1 cycle, 3 cycles after the request, with imem_load=0x00A00093.
- imem_ren and dmem_ren raised in the same cycle (dmem_addr=0x200) -> data access granted first; dhit pulses, then the fetch is granted; ihit pulses 3 cycles after dhit.
- dmem_ren held continuously with imem_ren=1, STARVE_MAX=4 -> 4 data grants, then 1 fetch grant; counter back at 0 after ihit.
- Store byte: dmem_wen=1, addr=0x203, store=0x123456AB -> ram_wstrb=4'b1000, ram_wdata=0xABABABAB, ram_addr=0x200. Load half: addr=0x202, rdata=0xBEEF1234 -> dmem_load=0x0000BEEF.
- Word load at addr=0x201 -> ram_addr=0x200, dhit and dmem_misaligned pulse together. ram_ready delayed 5 cycles -> ram_req and ram_addr held stable throughout.
- nRST asserted mid-DACC with ram_req=1 -> ram_req=0 immediately; after release, a stale ram_ready is ignored, no hit pulses, state=IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port RAM between the instruction fetch and
//               the data load/store path. Data has priority, with a fetch
//               anti-starvation limit. Also generates byte strobes and aligns
//               sub-word loads.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LDST_WIDTH_W = 2,
    parameter int STARVE_MAX   = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    imem_ren,
    input  logic [ADDR_W-1:0]       imem_addr,
    input  logic                    dmem_ren,
    input  logic                    dmem_wen,
    input  logic [ADDR_W-1:0]       dmem_addr,
    input  logic [DATA_W-1:0]       dmem_store,
    input  logic [LDST_WIDTH_W-1:0] dmem_width,
    output logic [DATA_W-1:0]       imem_load,
    output logic                    ihit,
    output logic [DATA_W-1:0]       dmem_load,
    output logic                    dhit,
    output logic                    dmem_misaligned,
    output logic                    ram_req,
    output logic                    ram_wen,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [3:0]              ram_wstrb,
    output logic [DATA_W-1:0]       ram_wdata,
    input  logic [DATA_W-1:0]       ram_rdata,
    input  logic                    ram_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);
    localparam logic [1:0] c_kind_byte  = 2'd0;
    localparam logic [1:0] c_kind_half  = 2'd1;
    localparam logic [1:0] c_kind_word  = 2'd2;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_starve;
    logic                w_dreq;
    logic                w_starved;
    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_done;

    logic                r_is_data;
    logic [1:0]          r_kind;
    logic [1:0]          r_off;
    logic                r_misal;

    logic [1:0]          w_kind;
    logic [1:0]          w_off;
    logic [3:0]          w_strb;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_misal;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_aligned;
    logic                w_unused;

    // Fetches are always whole words, so the low fetch address bits are dead.
    assign w_unused  = &{1'b0, imem_addr[1:0]};

    assign w_dreq    = dmem_ren | dmem_wen;
    assign w_starved = imem_ren && (r_starve == c_starve_max);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq && !w_starved) begin
                    w_state_nxt = DACC;
                    w_grant_d   = 1'b1;
                end else if (imem_ren) begin
                    w_state_nxt = IACC;
                    w_grant_i   = 1'b1;
                end
            end
            DACC, IACC: begin
                if (ram_ready) begin
                    w_state_nxt = RESP;
                    w_done      = 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Lane offset is masked to the access width, so misaligned accesses
    // still hit a naturally aligned lane group.
    always_comb begin
        w_kind  = c_kind_word;
        w_off   = 2'd0;
        w_strb  = 4'b1111;
        w_wdata = dmem_store;
        w_misal = |dmem_addr[1:0];
        case (dmem_width)
            LDST_WIDTH_W'(0): begin
                w_kind  = c_kind_byte;
                w_off   = dmem_addr[1:0];
                w_strb  = 4'b0001 << dmem_addr[1:0];
                w_wdata = {4{dmem_store[7:0]}};
                w_misal = 1'b0;
            end
            LDST_WIDTH_W'(1): begin
                w_kind  = c_kind_half;
                w_off   = {dmem_addr[1], 1'b0};
                w_strb  = dmem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{dmem_store[15:0]}};
                w_misal = dmem_addr[0];
            end
            default: ;
        endcase
    end

    assign w_shifted = ram_rdata >> {r_off, 3'b000};

    always_comb begin
        w_aligned = ram_rdata;
        case (r_kind)
            c_kind_byte: w_aligned = {24'd0, w_shifted[7:0]};
            c_kind_half: w_aligned = {16'd0, w_shifted[15:0]};
            default:     w_aligned = ram_rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve <= 4'd0;
        end else if (r_state == IDLE) begin
            if (!imem_ren || w_grant_i) begin
                r_starve <= 4'd0;
            end else if (w_grant_d && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ram_req         <= 1'b0;
            ram_wen         <= 1'b0;
            ram_addr        <= '0;
            ram_wstrb       <= 4'b0000;
            ram_wdata       <= '0;
            imem_load       <= '0;
            dmem_load       <= '0;
            ihit            <= 1'b0;
            dhit            <= 1'b0;
            dmem_misaligned <= 1'b0;
            r_is_data       <= 1'b0;
            r_kind          <= c_kind_word;
            r_off           <= 2'd0;
            r_misal         <= 1'b0;
        end else begin
            ihit            <= 1'b0;
            dhit            <= 1'b0;
            dmem_misaligned <= 1'b0;
            if (w_grant_d) begin
                ram_req   <= 1'b1;
                ram_wen   <= dmem_wen;
                ram_addr  <= {dmem_addr[ADDR_W-1:2], 2'b00};
                ram_wstrb <= dmem_wen ? w_strb : 4'b0000;
                ram_wdata <= w_wdata;
                r_is_data <= 1'b1;
                r_kind    <= w_kind;
                r_off     <= w_off;
                r_misal   <= w_misal;
            end else if (w_grant_i) begin
                ram_req   <= 1'b1;
                ram_wen   <= 1'b0;
                ram_addr  <= {imem_addr[ADDR_W-1:2], 2'b00};
                ram_wstrb <= 4'b0000;
                ram_wdata <= '0;
                r_is_data <= 1'b0;
                r_kind    <= c_kind_word;
                r_off     <= 2'd0;
                r_misal   <= 1'b0;
            end else if (w_done) begin
                ram_req   <= 1'b0;
                ram_wen   <= 1'b0;
                ram_wstrb <= 4'b0000;
                if (r_is_data) begin
                    dmem_load       <= w_aligned;
                    dhit            <= 1'b1;
                    dmem_misaligned <= r_misal;
                end else begin
                    imem_load <= ram_rdata;
                    ihit      <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios plus
//               randomized traffic against a byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        CLK;
    logic        nRST;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    logic [1:0]  dmem_width;
    logic [31:0] imem_load;
    logic        ihit;
    logic [31:0] dmem_load;
    logic        dhit;
    logic        dmem_misaligned;
    logic        ram_req;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    logic        resp_ready;
    logic        stale_ready;
    int          ram_delay;
    int          wcnt;
    logic        poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;
    logic [31:0] rmem [0:255];
    bit          wrv  [0:255];
    logic [7:0]  gmem [0:1023];

    int          checks;
    int          failures;
    int          cyc;
    int          cnt;
    logic        exp_f;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LDST_WIDTH_W(2), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .imem_ren(imem_ren), .imem_addr(imem_addr),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_store(dmem_store), .dmem_width(dmem_width),
        .imem_load(imem_load), .ihit(ihit),
        .dmem_load(dmem_load), .dhit(dhit), .dmem_misaligned(dmem_misaligned),
        .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign ram_ready = resp_ready | stale_ready;

    function automatic logic [7:0] f_init(int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    function automatic logic [31:0] rd_word(logic [31:0] cur, bit valid, int idx);
        if (valid) return cur;
        return {f_init(4*idx+3), f_init(4*idx+2), f_init(4*idx+1), f_init(4*idx)};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] cur, logic [31:0] wd, logic [3:0] st);
        logic [31:0] r;
        r = cur;
        for (int k = 0; k < 4; k++) if (st[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // RAM responder: ready after ram_delay extra cycles of ram_req.
    always @(negedge CLK) begin
        if (poke_en) begin
            rmem[poke_idx] <= poke_val;
            wrv[poke_idx]  <= 1'b1;
        end else if (resp_ready) begin
            resp_ready <= 1'b0;
        end else if (ram_req) begin
            if (wcnt >= ram_delay) begin
                resp_ready <= 1'b1;
                wcnt       <= 0;
                ram_rdata  <= rd_word(rmem[ram_addr[9:2]], wrv[ram_addr[9:2]], int'(ram_addr[9:2]));
                if (ram_wen) begin
                    rmem[ram_addr[9:2]] <= merge(rd_word(rmem[ram_addr[9:2]], wrv[ram_addr[9:2]],
                                                 int'(ram_addr[9:2])), ram_wdata, ram_wstrb);
                    wrv[ram_addr[9:2]]  <= 1'b1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] v);
        int b;
        b = int'(addr & 32'h3FC);
        for (int i = 0; i < 4; i++) gmem[b+i] = v[8*i +: 8];
        @(posedge CLK);
        poke_idx = addr[9:2];
        poke_val = v;
        poke_en  = 1'b1;
        @(posedge CLK);
        poke_en  = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int delay);
        int          b;
        int          c;
        int          reqc;
        logic [31:0] exp;
        b   = int'(addr & 32'h3FC);
        exp = {gmem[b+3], gmem[b+2], gmem[b+1], gmem[b]};
        ram_delay = delay;
        @(negedge CLK);
        imem_ren  = 1'b1;
        imem_addr = addr;
        c = 0;
        reqc = 0;
        do begin
            @(negedge CLK);
            c++;
            if (ram_req) begin
                reqc++;
                chk("fetch_ram_addr", ram_addr, addr & 32'h3FC);
                chk("fetch_ram_wen", 32'(ram_wen), 32'd0);
                chk("fetch_ram_wstrb", 32'(ram_wstrb), 32'd0);
            end
        end while (!ihit && c < 40);
        chk("fetch_latency", 32'(c), 32'(2 + delay));
        chk("fetch_req_cycles", 32'(reqc), 32'(delay + 1));
        chk("fetch_dhit_quiet", 32'(dhit), 32'd0);
        chk("imem_load", imem_load, exp);
        imem_ren = 1'b0;
    endtask

    task automatic do_data(input logic wen, input logic ren, input logic [31:0] addr,
                           input logic [1:0] width, input logic [31:0] store, input int delay);
        int          n;
        int          lane;
        int          b;
        int          c;
        int          reqc;
        logic [31:0] exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        logic        exp_mis;
        n    = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
        lane = (width == 2'd0) ? int'(addr[1:0]) : (width == 2'd1) ? 2 * int'(addr[1]) : 0;
        b    = int'(addr & 32'h3FC);
        exp_mis   = (width == 2'd1 && addr[0]) || (width[1] && addr[1:0] != 2'd0);
        exp_strb  = wen ? 32'(((1 << n) - 1) << lane) : 32'd0;
        exp_load  = 32'd0;
        for (int k = 0; k < 4; k++) exp_wdata[8*k +: 8] = store[8*(k % n) +: 8];
        for (int i = 0; i < n; i++) exp_load[8*i +: 8] = gmem[b+lane+i];
        if (wen) for (int i = 0; i < n; i++) gmem[b+lane+i] = store[8*i +: 8];
        ram_delay = delay;
        @(negedge CLK);
        dmem_wen   = wen;
        dmem_ren   = ren;
        dmem_addr  = addr;
        dmem_width = width;
        dmem_store = store;
        c = 0;
        reqc = 0;
        do begin
            @(negedge CLK);
            c++;
            if (ram_req) begin
                reqc++;
                chk("data_ram_addr", ram_addr, addr & 32'h3FC);
                chk("data_ram_wen", 32'(ram_wen), 32'(wen));
                chk("data_ram_wstrb", 32'(ram_wstrb), exp_strb);
                if (wen) chk("data_ram_wdata", ram_wdata, exp_wdata);
            end
        end while (!dhit && c < 40);
        chk("data_latency", 32'(c), 32'(2 + delay));
        chk("data_req_cycles", 32'(reqc), 32'(delay + 1));
        chk("data_ihit_quiet", 32'(ihit), 32'd0);
        chk("data_misaligned", 32'(dmem_misaligned), 32'(exp_mis));
        if (!wen) chk("dmem_load", dmem_load, exp_load);
        dmem_wen = 1'b0;
        dmem_ren = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        nRST = 1'b0; imem_ren = 1'b0; imem_addr = 32'd0;
        dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = 32'd0;
        dmem_store = 32'd0; dmem_width = 2'd0;
        resp_ready = 1'b0; stale_ready = 1'b0; wcnt = 0; ram_delay = 0;
        ram_rdata = 32'd0; poke_en = 1'b0; poke_idx = 8'd0; poke_val = 32'd0;
        for (int i = 0; i < 1024; i++) gmem[i] = f_init(i);

        repeat (2) @(negedge CLK);
        chk("rst_ram_req", 32'(ram_req), 32'd0);
        chk("rst_ram_wen", 32'(ram_wen), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wstrb", 32'(ram_wstrb), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_dhit", 32'(dhit), 32'd0);
        chk("rst_imem_load", imem_load, 32'd0);
        chk("rst_dmem_load", dmem_load, 32'd0);
        chk("rst_misaligned", 32'(dmem_misaligned), 32'd0);
        nRST = 1'b1;

        set_word(32'h100, 32'h00A00093);
        do_fetch(32'h100, 0);

        // Fetch and load raised together: data first, fetch three cycles later.
        @(negedge CLK);
        imem_ren = 1'b1; imem_addr = 32'h104;
        dmem_ren = 1'b1; dmem_addr = 32'h200; dmem_width = 2'd2;
        ram_delay = 0;
        cyc = 0;
        do begin @(negedge CLK); cyc++; end while (!(ihit | dhit) && cyc < 20);
        chk("simul_first_dhit", 32'(dhit), 32'd1);
        chk("simul_first_ihit", 32'(ihit), 32'd0);
        dmem_ren = 1'b0;
        cyc = 0;
        do begin @(negedge CLK); cyc++; end while (!ihit && cyc < 20);
        chk("simul_ihit_gap", 32'(cyc), 32'd3);
        imem_ren = 1'b0;

        // Both held: data wins until STARVE_MAX grants, then one fetch.
        @(negedge CLK);
        imem_ren = 1'b1; imem_addr = 32'h100;
        dmem_ren = 1'b1; dmem_addr = 32'h040; dmem_width = 2'd2;
        cnt = 0;
        for (int g = 0; g < 10; g++) begin
            exp_f = (cnt == STARVE_MAX);
            if (exp_f) cnt = 0; else cnt++;
            cyc = 0;
            do begin @(negedge CLK); cyc++; end while (!(ihit | dhit) && cyc < 20);
            chk($sformatf("starve_grant%0d_ihit", g), 32'(ihit), 32'(exp_f));
            chk($sformatf("starve_grant%0d_dhit", g), 32'(dhit), 32'(!exp_f));
        end
        imem_ren = 1'b0;
        dmem_ren = 1'b0;

        do_data(1'b1, 1'b0, 32'h203, 2'd0, 32'h123456AB, 0);
        set_word(32'h200, 32'hBEEF1234);
        do_data(1'b0, 1'b1, 32'h202, 2'd1, 32'd0, 0);
        chk("half_load_value", dmem_load, 32'h0000BEEF);
        do_data(1'b0, 1'b1, 32'h201, 2'd2, 32'd0, 5);
        do_data(1'b1, 1'b1, 32'h0A1, 2'd1, 32'hCAFE5A5A, 2);
        do_data(1'b0, 1'b1, 32'h0A0, 2'd2, 32'd0, 1);

        // Reset in the middle of a data access, then a stale ready.
        ram_delay = 20;
        @(negedge CLK);
        dmem_ren = 1'b1; dmem_addr = 32'h080; dmem_width = 2'd2;
        @(negedge CLK);
        chk("midrst_req_before", 32'(ram_req), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("midrst_req_async", 32'(ram_req), 32'd0);
        chk("midrst_addr_async", ram_addr, 32'd0);
        dmem_ren = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        ram_delay = 0;
        @(negedge CLK);
        stale_ready = 1'b1;
        @(negedge CLK);
        stale_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stale_quiet", {29'd0, ihit, dhit, ram_req}, 32'd0);
        end
        do_fetch(32'h100, 0);

        for (int t = 0; t < 40; t++) begin
            int          kind;
            int          op;
            int          dl;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            op   = int'($urandom_range(0, 2));
            dl   = int'($urandom_range(0, 3));
            a    = 32'($urandom_range(0, 255));
            if (kind < 3) do_fetch(a, dl);
            else do_data(op != 0, op != 1, a, 2'($urandom_range(0, 3)), $urandom, dl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
